psec6_ch_ctrl: RTL and testbench
================================

Name: psec6_ch_ctrl

Overview:
Parametrised per-channel sampling controller for the PSEC6 front end. It sequences N_BANKS fast SCA banks plus one slow bank through trigger-driven ping-pong groups. Trigger qualification uses a programmable delay line and a start hold-off. On command it snapshots the bank counters and streams them out over a valid/ready word interface. All logic is synchronous to FCLK and sits between the SPI/command decoder and the analog bank write-strobe drivers.

Parameters:
N_BANKS, 4, fast bank count; power of 2, from 2 to 16
CNT_W, 10, width of each bank counter; at most 16
DLY_DEPTH, 32, trigger delay line length in FCLK cycles; power of 2
HOLDOFF, 32, cycles after start during which triggers are ignored

Ports:
FCLK  in  1  clock
RSTB  in  1  asynchronous active-low reset
inst_start  in  1  single-cycle start pulse, FCLK domain
inst_stop  in  1  single-cycle stop pulse
inst_readout  in  1  single-cycle readout pulse
mode  in  2  log2 of banks per group: 0 = 1 bank, 1 = 2 banks, 2 or 3 = all banks
disc_in  in  1  asynchronous discriminator output
disc_pol  in  1  1 inverts disc_in
trig_delay  in  $clog2(DLY_DEPTH)  delay tap; 0 selects the synchronized input directly
bank_cnt  in  (N_BANKS+1)*CNT_W  counters, bank 0 in the LSBs, slow bank last
bank_en_n  out  N_BANKS  active-low write enable per fast bank
slow_en_n  out  1  active-low slow bank enable
stop_request  out  1  sticky high after the first accepted trigger
trig_cnt  out  5  accepted triggers since start
rd_data  out  16  readout word
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accept
busy  out  1  high in SAMPLING, SLOW_ONLY or READOUT

Behaviour:
- Reset values: state IDLE; bank_en_n all 1; slow_en_n 1; stop_request 0; trig_cnt 0; rd_valid 0; rd_data 0; delay line 0.
- disc_in passes through a 2-flop synchronizer, is XORed with disc_pol, then enters the DLY_DEPTH shift register. Tap k is the qualified signal delayed k cycles after synchronization.
- Trigger = rising edge of the tapped signal, with state SAMPLING and the hold-off counter at 0. Only one trigger fires per edge; a level held high produces one trigger.
- The hold-off counter loads HOLDOFF on an accepted inst_start and decrements to 0. Triggers are ignored while it is nonzero.
- Group size G = min(2^mode, N_BANKS), with mode 3 treated as mode 2 and then clipped. NGRP = N_BANKS/G. mode is latched at start.
- States and transitions:
  - IDLE: all banks disabled. Start goes to SAMPLING with grp=0, trig_cnt=0, stop_request=0.
  - SAMPLING: bank_en_n[i]=0 iff i/G == grp; slow_en_n=0. A trigger increments trig_cnt, sets stop_request, and increments grp. A trigger with grp=NGRP-1 goes to SLOW_ONLY.
  - SLOW_ONLY: fast banks disabled; slow_en_n=0.
  - STOPPED: all banks disabled; counters hold.
  - READOUT: all banks disabled; serializer active. After the last word is accepted, go to STOPPED.
- Command priority: RSTB > start > stop > readout > trigger.
  - Stop from any state except IDLE goes to STOPPED. Stop in IDLE is ignored.
  - Readout from any state latches bank_cnt and trig_cnt into the snapshot register on the same edge and enters READOUT.
- Outputs are registered. bank_en_n changes 1 cycle after the triggering edge is detected. Total latency from a disc_in edge to bank_en_n is 4+trig_delay cycles.
- trig_cnt saturates at 31.
- Readout words, in order:
  - Word 0: {trig_cnt[4:0], grp[3:0], state-at-readout[2:0], mode_latched[1:0], 2'b00}.
  - Words 1 to N_BANKS+1: bank counters 0 to N_BANKS, zero-extended to 16 bits.
- Handshake: rd_data and rd_valid are held until a cycle with rd_valid & rd_ready. The next word appears on the following cycle; a consumer holding rd_ready high gets back-to-back words.
- Start during READOUT aborts the readout: rd_valid drops next cycle and state goes to SAMPLING. Readout during READOUT restarts the snapshot from word 0.
- RSTB mid-operation clears everything asynchronously. The synchronizer also clears.

Optional Feature:
Macro PSEC6_TRIG_TIMESTAMP_EN.
- When defined: a 16-bit free-running FCLK cycle counter, cleared on start, is captured on each accepted trigger into a per-group register (NGRP max = N_BANKS entries). These N_BANKS timestamp words are appended after the counter words; unused entries read 0.
- When undefined: no timestamp logic; the readout is exactly N_BANKS+2 words.

Decomposition:
- Package psec6_ch_pkg holds:
  - state enum ch_state_t (IDLE, SAMPLING, SLOW_ONLY, STOPPED, READOUT);
  - mode encoding constants;
  - header field offsets;
  - function readout_words(N_BANKS), returning N_BANKS+2, plus N_BANKS when timestamps are enabled.
- Sub-module psec6_trig_qual contains the synchronizer, polarity XOR, delay line, tap mux, edge detect and hold-off. It outputs a single-cycle trig_pulse.

Test Plan:
- N_BANKS=4, mode=0, start, then 4 disc pulses after the hold-off (trig_delay=0): bank_en_n steps 1110, 1101, 1011, 0111, then 1111 with slow_en_n=0; trig_cnt=4; stop_request high after the first pulse.
- mode=1: 2 pulses give bank_en_n 1100, 0011, then 1111 with state SLOW_ONLY. mode=3 behaves as mode 2: bank_en_n 0000, then SLOW_ONLY after 1 trigger.
- A disc pulse 10 cycles after start with HOLDOFF=32 is ignored (trig_cnt=0). A pulse at cycle 40 with trig_delay=5 changes bank_en_n at cycle 40+4+5.
- Readout with bank_cnt = 0x3FF, 0x001, 0x155, 0x2AA, 0x0F0 and rd_ready toggling every other cycle: 6 words, each held stable while rd_ready=0, values match; state goes to STOPPED after word 5.
- Start and trigger in the same cycle: start wins, grp=0, trig_cnt=0. Stop and readout in the same cycle: STOPPED, no rd_valid.
- RSTB low mid-readout at word 3: rd_valid=0 and all enables 1 immediately; after release, state is IDLE and a held-high disc_in produces no trigger.

Source files
------------

// File: rtl/psec6_ch_pkg.sv
// Shared types and constants for the PSEC6 channel sampling controller.
// PSEC6_TRIG_TIMESTAMP_EN extends the readout with per-group trigger timestamps.
package psec6_ch_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SAMPLING  = 3'd1,
    SLOW_ONLY = 3'd2,
    STOPPED   = 3'd3,
    READOUT   = 3'd4
  } ch_state_t;

  localparam logic [1:0] MODE_G1   = 2'd0;
  localparam logic [1:0] MODE_G2   = 2'd1;
  localparam logic [1:0] MODE_GALL = 2'd2;

  localparam int unsigned HDR_MODE_LSB  = 2;
  localparam int unsigned HDR_STATE_LSB = 4;
  localparam int unsigned HDR_GRP_LSB   = 7;
  localparam int unsigned HDR_TRIG_LSB  = 11;

  function automatic int unsigned readout_words(input int unsigned n_banks);
`ifdef PSEC6_TRIG_TIMESTAMP_EN
    return 2 * n_banks + 2;
`else
    return n_banks + 2;
`endif
  endfunction

  // log2 of the group size: mode 3 folds onto mode 2, then clipped to the bank count
  function automatic logic [2:0] grp_shift(input logic [1:0] m, input int unsigned lg_max);
    int unsigned s;
    if (m == MODE_G1)      s = 0;
    else if (m == MODE_G2) s = 1;
    else                   s = 2;
    if (s > lg_max) s = lg_max;
    return 3'(s);
  endfunction

endpackage

// File: rtl/psec6_ch_ctrl_trig_qual.sv
// Trigger qualification: synchronizer, polarity, programmable delay tap,
// rising-edge detect and start hold-off; emits a registered single-cycle pulse.
module psec6_trig_qual #(
  parameter int unsigned DLY_DEPTH = 32,
  parameter int unsigned HOLDOFF   = 32
) (
  input  logic                         FCLK,
  input  logic                         RSTB,
  input  logic                         disc_i,
  input  logic                         pol_i,
  input  logic [$clog2(DLY_DEPTH)-1:0] tap_i,
  input  logic                         start_i,
  input  logic                         sampling_i,
  output logic                         trig_pulse_o
);

  localparam int unsigned HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic [1:0]           sync_q;
  logic [DLY_DEPTH-2:0] dly_q;
  logic [DLY_DEPTH-1:0] taps;
  logic                 qual;
  logic                 tap_sel;
  logic                 tap_prev_q;
  logic                 trig_q;
  logic [HO_W-1:0]      hold_q;
  logic [HO_W-1:0]      hold_d;

  // Tap 0 is the synchronized signal itself, tap k is k flops further down
  always_comb begin
    qual    = sync_q[1] ^ pol_i;
    taps    = {dly_q, qual};
    tap_sel = taps[tap_i];
  end

  always_comb begin
    hold_d = hold_q;
    if (start_i)              hold_d = HO_W'(HOLDOFF);
    else if (hold_q != '0)    hold_d = hold_q - HO_W'(1);
  end

  always_ff @(posedge FCLK or negedge RSTB) begin
    if (!RSTB) begin
      sync_q     <= '0;
      dly_q      <= '0;
      tap_prev_q <= 1'b0;
      hold_q     <= '0;
      trig_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], disc_i};
      dly_q      <= taps[DLY_DEPTH-2:0];
      tap_prev_q <= tap_sel;
      hold_q     <= hold_d;
      trig_q     <= tap_sel & ~tap_prev_q & sampling_i & (hold_q == '0) & ~start_i;
    end
  end

  assign trig_pulse_o = trig_q;

endmodule

// File: rtl/psec6_ch_ctrl.sv
// PSEC6 per-channel sampling controller: ping-pong bank groups, trigger counting
// and counter snapshot readout. Define PSEC6_TRIG_TIMESTAMP_EN for trigger timestamps.
module psec6_ch_ctrl #(
  parameter int unsigned N_BANKS   = 4,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned DLY_DEPTH = 32,
  parameter int unsigned HOLDOFF   = 32
) (
  input  logic                           FCLK,
  input  logic                           RSTB,
  input  logic                           inst_start,
  input  logic                           inst_stop,
  input  logic                           inst_readout,
  input  logic [1:0]                     mode,
  input  logic                           disc_in,
  input  logic                           disc_pol,
  input  logic [$clog2(DLY_DEPTH)-1:0]   trig_delay,
  input  logic [(N_BANKS+1)*CNT_W-1:0]   bank_cnt,
  output logic [N_BANKS-1:0]             bank_en_n,
  output logic                           slow_en_n,
  output logic                           stop_request,
  output logic [4:0]                     trig_cnt,
  output logic [15:0]                    rd_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic                           busy
);
  import psec6_ch_pkg::*;

  localparam int unsigned LG_MAX = $clog2(N_BANKS);
  localparam int unsigned NWORDS = readout_words(N_BANKS);
  localparam int unsigned IDX_W  = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  ch_state_t            state_q, state_d;
  logic [3:0]           grp_q, grp_d;
  logic [4:0]           trig_cnt_q, trig_cnt_d;
  logic                 stop_req_q, stop_req_d;
  logic [1:0]           mode_q, mode_d;
  logic [IDX_W-1:0]     idx_q, idx_d, nidx;
  logic                 rd_valid_q, rd_valid_d;
  logic [15:0]          rd_data_q, rd_data_d;
  logic [N_BANKS-1:0]   bank_en_n_q, bank_en_n_d;
  logic                 slow_en_n_q, slow_en_n_d;
  logic [CNT_W-1:0]     snap_q [N_BANKS+1];
  logic                 snap_ld;
  logic                 trig_pulse;
  logic                 trig_acc;
  logic [2:0]           lg_q, lg_d;
  logic [3:0]           grp_last;
  logic [15:0]          hdr;
  logic [15:0]          next_word;

  psec6_trig_qual #(
    .DLY_DEPTH (DLY_DEPTH),
    .HOLDOFF   (HOLDOFF)
  ) u_trig_qual (
    .FCLK         (FCLK),
    .RSTB         (RSTB),
    .disc_i       (disc_in),
    .pol_i        (disc_pol),
    .tap_i        (trig_delay),
    .start_i      (inst_start),
    .sampling_i   (state_q == SAMPLING),
    .trig_pulse_o (trig_pulse)
  );

`ifdef PSEC6_TRIG_TIMESTAMP_EN
  logic [15:0] ts_ctr_q;
  logic [15:0] ts_q [N_BANKS];

  always_ff @(posedge FCLK or negedge RSTB) begin
    if (!RSTB) begin
      ts_ctr_q <= '0;
      for (int unsigned k = 0; k < N_BANKS; k++) ts_q[k] <= '0;
    end else if (inst_start) begin
      ts_ctr_q <= '0;
      for (int unsigned k = 0; k < N_BANKS; k++) ts_q[k] <= '0;
    end else begin
      ts_ctr_q <= ts_ctr_q + 16'd1;
      if (trig_acc) begin
        for (int unsigned k = 0; k < N_BANKS; k++)
          if (grp_q == 4'(k)) ts_q[k] <= ts_ctr_q;
      end
    end
  end
`endif

  always_comb begin
    lg_q     = grp_shift(mode_q, LG_MAX);
    grp_last = 4'((N_BANKS >> lg_q) - 1);
    trig_acc = trig_pulse && (state_q == SAMPLING) && !inst_start && !inst_stop && !inst_readout;
    hdr      = (16'(trig_cnt_q) << HDR_TRIG_LSB) | (16'(grp_q) << HDR_GRP_LSB) |
               (16'(state_q) << HDR_STATE_LSB) | (16'(mode_q) << HDR_MODE_LSB);
  end

  // Word after the current one; word 0 (header) is only ever loaded by the readout command
  always_comb begin
    next_word = '0;
    nidx      = idx_q + IDX_W'(1);
    for (int unsigned k = 0; k <= N_BANKS; k++)
      if (nidx == IDX_W'(k + 1)) next_word = 16'(snap_q[k]);
`ifdef PSEC6_TRIG_TIMESTAMP_EN
    for (int unsigned k = 0; k < N_BANKS; k++)
      if (nidx == IDX_W'(N_BANKS + 2 + k)) next_word = ts_q[k];
`endif
  end

  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    trig_cnt_d = trig_cnt_q;
    stop_req_d = stop_req_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    snap_ld    = 1'b0;

    if (inst_start) begin
      state_d    = SAMPLING;
      grp_d      = '0;
      trig_cnt_d = '0;
      stop_req_d = 1'b0;
      mode_d     = mode;
      rd_valid_d = 1'b0;
    end else if (inst_stop && state_q != IDLE) begin
      state_d    = STOPPED;
      rd_valid_d = 1'b0;
    end else if (inst_readout) begin
      state_d    = READOUT;
      snap_ld    = 1'b1;
      idx_d      = '0;
      rd_valid_d = 1'b1;
      rd_data_d  = hdr;
    end else if (state_q == READOUT) begin
      if (rd_valid_q && rd_ready) begin
        if (idx_q == LAST_IDX) begin
          rd_valid_d = 1'b0;
          state_d    = STOPPED;
        end else begin
          idx_d     = nidx;
          rd_data_d = next_word;
        end
      end
    end else if (trig_acc) begin
      if (trig_cnt_q != 5'd31) trig_cnt_d = trig_cnt_q + 5'd1;
      stop_req_d = 1'b1;
      grp_d      = grp_q + 4'd1;
      if (grp_q == grp_last) state_d = SLOW_ONLY;
    end

    // Enables are computed from next state so they register alongside it
    lg_d        = grp_shift(mode_d, LG_MAX);
    bank_en_n_d = '1;
    slow_en_n_d = 1'b1;
    if (state_d == SAMPLING) begin
      slow_en_n_d = 1'b0;
      for (int unsigned i = 0; i < N_BANKS; i++)
        if (4'(i >> lg_d) == grp_d) bank_en_n_d[i] = 1'b0;
    end else if (state_d == SLOW_ONLY) begin
      slow_en_n_d = 1'b0;
    end
  end

  always_ff @(posedge FCLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      trig_cnt_q  <= '0;
      stop_req_q  <= 1'b0;
      mode_q      <= '0;
      idx_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      bank_en_n_q <= '1;
      slow_en_n_q <= 1'b1;
      for (int unsigned k = 0; k <= N_BANKS; k++) snap_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      trig_cnt_q  <= trig_cnt_d;
      stop_req_q  <= stop_req_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      bank_en_n_q <= bank_en_n_d;
      slow_en_n_q <= slow_en_n_d;
      if (snap_ld) begin
        for (int unsigned k = 0; k <= N_BANKS; k++)
          snap_q[k] <= bank_cnt[k*CNT_W +: CNT_W];
      end
    end
  end

  assign bank_en_n    = bank_en_n_q;
  assign slow_en_n    = slow_en_n_q;
  assign stop_request = stop_req_q;
  assign trig_cnt     = trig_cnt_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = (state_q == SAMPLING) || (state_q == SLOW_ONLY) || (state_q == READOUT);

endmodule

// File: tb/tb_psec6_ch_ctrl.sv
// Directed bench for psec6_ch_ctrl (default build, N_BANKS=4, CNT_W=10).
module tb_psec6_ch_ctrl;

  logic        FCLK = 1'b0;
  logic        RSTB;
  logic        inst_start, inst_stop, inst_readout;
  logic [1:0]  mode;
  logic        disc_in, disc_pol;
  logic [4:0]  trig_delay;
  logic [49:0] bank_cnt;
  logic [3:0]  bank_en_n;
  logic        slow_en_n, stop_request;
  logic [4:0]  trig_cnt;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready, busy;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  psec6_ch_ctrl #(
    .N_BANKS   (4),
    .CNT_W     (10),
    .DLY_DEPTH (32),
    .HOLDOFF   (32)
  ) dut (
    .FCLK         (FCLK),
    .RSTB         (RSTB),
    .inst_start   (inst_start),
    .inst_stop    (inst_stop),
    .inst_readout (inst_readout),
    .mode         (mode),
    .disc_in      (disc_in),
    .disc_pol     (disc_pol),
    .trig_delay   (trig_delay),
    .bank_cnt     (bank_cnt),
    .bank_en_n    (bank_en_n),
    .slow_en_n    (slow_en_n),
    .stop_request (stop_request),
    .trig_cnt     (trig_cnt),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy)
  );

  always #5 FCLK = ~FCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge FCLK);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m);
    mode = m; inst_start = 1'b1; tick(1); inst_start = 1'b0;
  endtask

  task automatic do_stop();
    inst_stop = 1'b1; tick(1); inst_stop = 1'b0;
  endtask

  task automatic do_readout();
    inst_readout = 1'b1; tick(1); inst_readout = 1'b0;
  endtask

  // One-cycle disc pulse, returns 4 edges later when a tap-0 trigger has reached bank_en_n
  task automatic fire();
    disc_in = 1'b1; tick(1); disc_in = 1'b0; tick(3);
  endtask

  logic [3:0]  en_seq [4];
  logic [15:0] words  [6];

  initial begin
    inst_start = 0; inst_stop = 0; inst_readout = 0; mode = 0;
    disc_in = 0; disc_pol = 0; trig_delay = 0; bank_cnt = '0; rd_ready = 0;
    RSTB = 1'b1;
    #3 RSTB = 1'b0;
    tick(2);
    chk("rst_en", bank_en_n, 4'hF);
    chk("rst_slow", slow_en_n, 1);
    chk("rst_stopreq", stop_request, 0);
    chk("rst_trigcnt", trig_cnt, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    RSTB = 1'b1;
    tick(2);

    // mode 0: one bank per group
    en_seq[0] = 4'hD; en_seq[1] = 4'hB; en_seq[2] = 4'h7; en_seq[3] = 4'hF;
    do_start(2'd0);
    chk("m0_start_en", bank_en_n, 4'hE);
    chk("m0_busy", busy, 1);
    tick(35);
    for (int i = 0; i < 4; i++) begin
      fire();
      chk($sformatf("m0_en%0d", i), bank_en_n, en_seq[i]);
      if (i == 0) chk("m0_stopreq", stop_request, 1);
    end
    chk("m0_slow", slow_en_n, 0);
    chk("m0_trigcnt", trig_cnt, 4);

    // mode 1: two banks per group
    do_start(2'd1);
    chk("m1_start_en", bank_en_n, 4'hC);
    tick(35);
    fire();
    chk("m1_en1", bank_en_n, 4'h3);
    fire();
    chk("m1_en2", bank_en_n, 4'hF);
    chk("m1_slow", slow_en_n, 0);
    do_readout();
    chk("m1_hdr_valid", rd_valid, 1);
    chk("m1_hdr", rd_data, 16'h1124);
    chk("m1_ro_en", bank_en_n, 4'hF);
    chk("m1_ro_slow", slow_en_n, 1);
    do_stop();
    chk("m1_stop_valid", rd_valid, 0);
    chk("m1_stop_busy", busy, 0);

    // mode 3 folds to mode 2: all banks in one group
    do_start(2'd3);
    chk("m3_start_en", bank_en_n, 4'h0);
    tick(35);
    fire();
    chk("m3_en1", bank_en_n, 4'hF);
    chk("m3_slow", slow_en_n, 0);
    do_readout();
    chk("m3_hdr", rd_data, 16'h08AC);
    do_stop();

    // hold-off then delayed tap latency
    trig_delay = 5'd5;
    do_start(2'd0);
    tick(9);
    fire();
    tick(6);
    chk("ho_trigcnt", trig_cnt, 0);
    chk("ho_en", bank_en_n, 4'hE);
    tick(20);
    disc_in = 1'b1; tick(1); disc_in = 1'b0; tick(7);
    chk("dly_early", bank_en_n, 4'hE);
    tick(1);
    chk("dly_edge", bank_en_n, 4'hD);
    trig_delay = 5'd0;

    // readout with throttled consumer
    bank_cnt = {10'h0F0, 10'h2AA, 10'h155, 10'h001, 10'h3FF};
    words[0] = 16'h0890; words[1] = 16'h03FF; words[2] = 16'h0001;
    words[3] = 16'h0155; words[4] = 16'h02AA; words[5] = 16'h00F0;
    do_readout();
    chk("ro_en", bank_en_n, 4'hF);
    chk("ro_slow", slow_en_n, 1);
    chk("ro_busy", busy, 1);
    for (int w = 0; w < 6; w++) begin
      chk($sformatf("ro_valid%0d", w), rd_valid, 1);
      chk($sformatf("ro_word%0d", w), rd_data, words[w]);
      rd_ready = 1'b0; tick(1);
      chk($sformatf("ro_hold%0d", w), rd_data, words[w]);
      rd_ready = 1'b1; tick(1);
      rd_ready = 1'b0;
    end
    chk("ro_done_valid", rd_valid, 0);
    chk("ro_done_busy", busy, 0);

    // start coincident with a trigger
    do_start(2'd0);
    tick(35);
    disc_in = 1'b1; tick(1); disc_in = 1'b0; tick(2);
    do_start(2'd0);
    chk("st_tr_en", bank_en_n, 4'hE);
    chk("st_tr_trigcnt", trig_cnt, 0);
    chk("st_tr_stopreq", stop_request, 0);

    // stop coincident with readout
    inst_stop = 1'b1; inst_readout = 1'b1; tick(1);
    inst_stop = 1'b0; inst_readout = 1'b0;
    chk("sp_ro_busy", busy, 0);
    chk("sp_ro_valid", rd_valid, 0);
    do_readout();
    chk("sp_ro_hdr", rd_data, 16'h0030);

    // reset in the middle of a readout
    rd_ready = 1'b1; tick(3); rd_ready = 1'b0;
    chk("mid_word3", rd_data, 16'h0155);
    disc_in = 1'b1;
    #2 RSTB = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_en", bank_en_n, 4'hF);
    chk("arst_slow", slow_en_n, 1);
    chk("arst_busy", busy, 0);
    #3 RSTB = 1'b1;
    tick(10);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_trigcnt", trig_cnt, 0);
    chk("post_rst_stopreq", stop_request, 0);
    do_start(2'd0);
    tick(40);
    chk("level_trigcnt", trig_cnt, 0);
    chk("level_en", bank_en_n, 4'hE);
    do_readout();
    chk("level_hdr", rd_data, 16'h0010);
    disc_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
